apb_master_interface: RTL
=========================

Name: apb_master_interface

Overview:
APB initiator that turns a simple command/stream interface into AMBA 3 APB transfers towards the subsystem APB slave. It is used by the on-chip loader and the testbench host model to program instruction memory, fill the input buffer, issue control writes and drain the output buffer. A command is a burst of 1..2^LEN_W word transfers to incrementing addresses. Write data arrives on a valid/ready stream and read data leaves on one. PSLVERR and a wait-state timeout are reported per command.

Parameters:
APB_AW, 32, APB address width
APB_DW, 32, APB data width; the address step per beat is APB_DW/8
LEN_W, 8, width of cmd_len
TIMEOUT_CYCLES, 255, maximum ACCESS cycles without PREADY; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  APB_AW  start byte address, word aligned
cmd_len  in  LEN_W  number of beats minus 1
wr_valid  in  1  write data valid
wr_ready  out  1  write data accepted
wr_data  in  APB_DW  write data
rd_valid  out  1  read data valid
rd_ready  in  1  read data consumed
rd_data  out  APB_DW  read data
done_valid  out  1  one-cycle pulse at the end of a command
done_err  out  1  PSLVERR seen or timeout in this command; valid with done_valid
busy  out  1  high whenever the state is not IDLE
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  APB_AW  APB address
PWDATA  out  APB_DW  APB write data
PRDATA  in  APB_DW  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, except cmd_ready, which is 1.
  - Internal address, count, data, error and timeout registers are cleared.
  - Reset during a transfer forces PSEL=PENABLE=0 after that edge. No done pulse is issued.
- All APB outputs and rd_data are registered.
- PADDR, PWRITE and PWDATA are stable from SETUP until the ACCESS cycle that completes the transfer.
- FSM states: IDLE, WDATA, SETUP, ACCESS, RDHOLD, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_addr into PADDR, cmd_write into PWRITE, cmd_len into the beat counter, and clear err.
  - Next state is WDATA for a write, SETUP for a read.
- WDATA:
  - wr_ready=1 and PSEL=0.
  - On wr_valid: latch wr_data into PWDATA and go to SETUP.
  - wr_valid outside WDATA is ignored (wr_ready=0).
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; the timeout counter increments every cycle.
  - On PREADY=1 with PSLVERR=1: set err, abort the remaining beats, no rd beat, go to DONE.
  - On PREADY=1 with PSLVERR=0:
    - Read: capture PRDATA into rd_data and go to RDHOLD.
    - Write, last beat: go to DONE.
    - Write, otherwise: PADDR += APB_DW/8, decrement the counter, go to WDATA.
  - Timeout: TIMEOUT_CYCLES consecutive ACCESS cycles without PREADY. Then set err, drop PSEL/PENABLE on the next edge, and go to DONE.
  - The timeout counter clears on entry to SETUP.
- RDHOLD:
  - rd_valid=1 and rd_data held; PSEL=0.
  - On rd_ready, last beat: go to DONE.
  - On rd_ready, otherwise: PADDR += APB_DW/8, decrement the counter, go to SETUP.
- DONE:
  - done_valid=1 and done_err=err for one cycle.
  - cmd_ready=0, then IDLE.
  - A new command can be accepted on the cycle after DONE.
- PSEL=0 in every state except SETUP and ACCESS. Every beat therefore starts with a fresh SETUP phase; there are no back-to-back ACCESS phases.
- Address increment wraps modulo 2^APB_AW. Unaligned cmd_addr is passed through unchanged.
- Minimum throughput with a zero-wait slave:
  - Write beat: 3 cycles (WDATA, SETUP, ACCESS).
  - Read beat: 3 cycles (SETUP, ACCESS, RDHOLD).
  - The subsystem slave adds one wait state per transfer.

Test Plan:
- Single write, addr=0x0000_0040, len=0, data=0xDEADBEEF, zero-wait slave -> one SETUP cycle then one ACCESS cycle with PADDR=0x40, PWRITE=1, PWDATA=0xDEADBEEF; done_valid pulse with done_err=0; busy lasts 4 cycles.
- Read burst, addr=0x100, len=3, slave returns addr^0xA5A5A5A5 with 1 wait state -> PADDR sequence 0x100, 0x104, 0x108, 0x10C; 4 rd beats with matching data; with rd_ready held low 5 cycles on beat 2, rd_data stays stable and PSEL=0 throughout.
- Write burst, len=2, slave asserts PSLVERR on beat 1 -> beat 2 never issued; wr_ready never high again for that command; done_err=1.
- TIMEOUT_CYCLES=4, slave never asserts PREADY -> PSEL/PENABLE high for exactly 4 ACCESS cycles then low; done_err=1; the next command completes normally with done_err=0.
- Address wrap: addr=0xFFFF_FFFC, len=1, write -> second beat PADDR=0x0000_0000.
- Reset asserted during ACCESS of beat 2 of a 4-beat read -> PSEL=PENABLE=0 and rd_valid=0 the following cycle; no done pulse; cmd_ready=1.

Source files
------------

// File: rtl/apb_master_interface_if.sv
// Command/stream side and APB side of the APB initiator, bundled in one interface.
// master = the initiator's view; slave = the host plus APB target environment.
interface apb_master_interface_if #(
  parameter int APB_AW = 32,
  parameter int APB_DW = 32,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [APB_AW-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [APB_DW-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [APB_DW-1:0] rd_data;
  logic              done_valid;
  logic              done_err;
  logic              busy;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_AW-1:0] PADDR;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output done_valid, done_err, busy,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  done_valid, done_err, busy,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_interface.sv
// APB initiator: bursts of word transfers from a command, write data in, read data out.
// Every beat is a fresh SETUP+ACCESS; the streams stall the FSM in WDATA/RDHOLD.
module apb_master_interface #(
  parameter int APB_AW         = 32,
  parameter int APB_DW         = 32,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  apb_master_interface_if.master bus
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST  = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [APB_AW-1:0] ADDR_STEP = APB_AW'(APB_DW / 8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RDHOLD = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e            state_q;
  logic [APB_AW-1:0] paddr_q;
  logic [APB_DW-1:0] pwdata_q;
  logic [APB_DW-1:0] rd_data_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic              err_q;
  logic              cmd_ready_q;
  logic              wr_ready_q;
  logic              rd_valid_q;
  logic              done_valid_q;
  logic              done_err_q;
  logic              busy_q;
  logic              last_beat;
  logic              tmo_hit;

  assign last_beat = (cnt_q == '0);
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rd_data_q    <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      wr_ready_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            paddr_q     <= bus.cmd_addr;
            pwrite_q    <= bus.cmd_write;
            cnt_q       <= bus.cmd_len;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.cmd_write) begin
              wr_ready_q <= 1'b1;
              state_q    <= WDATA;
            end else begin
              psel_q  <= 1'b1;
              tmo_q   <= '0;
              state_q <= SETUP;
            end
          end
        end
        WDATA: begin
          if (bus.wr_valid) begin
            pwdata_q   <= bus.wr_data;
            wr_ready_q <= 1'b0;
            psel_q     <= 1'b1;
            tmo_q      <= '0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (bus.PSLVERR) begin
              // An error ends the whole command; remaining beats are dropped.
              err_q        <= 1'b1;
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b1;
              state_q      <= DONE;
            end else if (!pwrite_q) begin
              rd_data_q  <= bus.PRDATA;
              rd_valid_q <= 1'b1;
              state_q    <= RDHOLD;
            end else if (last_beat) begin
              done_valid_q <= 1'b1;
              done_err_q   <= err_q;
              state_q      <= DONE;
            end else begin
              paddr_q    <= paddr_q + ADDR_STEP;
              cnt_q      <= cnt_q - LEN_W'(1);
              wr_ready_q <= 1'b1;
              state_q    <= WDATA;
            end
          end else if (tmo_hit) begin
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            err_q        <= 1'b1;
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
            state_q      <= DONE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        RDHOLD: begin
          if (bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            if (last_beat) begin
              done_valid_q <= 1'b1;
              done_err_q   <= err_q;
              state_q      <= DONE;
            end else begin
              paddr_q <= paddr_q + ADDR_STEP;
              cnt_q   <= cnt_q - LEN_W'(1);
              psel_q  <= 1'b1;
              tmo_q   <= '0;
              state_q <= SETUP;
            end
          end
        end
        DONE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          wr_ready_q  <= 1'b0;
          rd_valid_q  <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.wr_ready   = wr_ready_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_err   = done_err_q;
  assign bus.busy       = busy_q;
  assign bus.PSEL       = psel_q;
  assign bus.PENABLE    = penable_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PADDR      = paddr_q;
  assign bus.PWDATA     = pwdata_q;

endmodule
